manchester_tx: RTL
==================

MANCHESTER_TX -- requirements
Module: manchester_tx

Interface
REQ-001 Parameter CLK_PER_HALF, default 4, SHALL set clk_8M cycles per Manchester half-bit (500 ns at 8 MHz).
REQ-002 Parameter GAP_CYCLES, default 16, SHALL set the minimum idle cycles enforced after each word (0 = no gap).
REQ-003 Port clk_8M, input, 1 bit, SHALL be the single clock. One clock; reset is asynchronous and active-low.
REQ-004 Port clrn, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port in_word, input, 16 bits, SHALL carry the data word; bit 15 is transmitted first.
REQ-006 Port in_type, input, 2 bits, SHALL select the sync: 2'b01 command/status, 2'b10 data; 2'b00 and 2'b11 are invalid.
REQ-007 Port in_valid, input, 1 bit, SHALL request transmission of in_word/in_type.
REQ-008 Port force_par_err, input, 1 bit, SHALL invert the transmitted parity bit of the word accepted in the same cycle.
REQ-009 Port in_ready, output, 1 bit, SHALL be high only when a word can be accepted.
REQ-010 Port data_out, output, 1 bit, SHALL be the registered serial Manchester line feeding the downstream decoder's data_in.
REQ-011 Port tx_busy, output, 1 bit, SHALL be high from acceptance until the end of the gap.
REQ-012 Port type_err, output, 1 bit, SHALL pulse for one cycle when in_valid is high with an invalid in_type while in_ready is high.

Function
REQ-013 Accept SHALL occur on a rising clk_8M edge where in_valid and in_ready are both high and in_type is valid; in_word, in_type and the computed parity are latched there.
REQ-014 Invalid in_type SHALL NOT be accepted; the state is unchanged and type_err pulses.
REQ-015 States SHALL be IDLE, SYNC, DATA, PARITY, GAP; in_ready = 1 only in IDLE.
REQ-016 IDLE -> SYNC on accept; SYNC -> DATA after 6*CLK_PER_HALF cycles; DATA -> PARITY after 16 bits; PARITY -> GAP after 2*CLK_PER_HALF cycles; GAP -> IDLE after GAP_CYCLES cycles (PARITY -> IDLE directly if GAP_CYCLES = 0).
REQ-017 data_out SHALL change to the first sync level on the cycle after acceptance (latency 1).
REQ-018 Command/status sync SHALL be 3*CLK_PER_HALF cycles high, then 3*CLK_PER_HALF cycles low; data sync is the inverse.
REQ-019 A logic 1 bit SHALL be CLK_PER_HALF cycles high then CLK_PER_HALF cycles low; a logic 0 SHALL be low then high.
REQ-020 The parity bit SHALL make the total number of ones across the 16 data bits and the parity bit odd, inverted when force_par_err was latched.
REQ-021 One word SHALL occupy exactly 40*CLK_PER_HALF cycles (160 at default) from the first sync cycle to the end of parity.
REQ-022 data_out SHALL be 0 in IDLE and GAP.
REQ-023 Input changes after acceptance SHALL NOT affect the word in flight.

Reset
REQ-024 While clrn = 0: state = IDLE, data_out = 0, tx_busy = 0, type_err = 0, all counters = 0; in_ready is high after release.
REQ-025 Reset asserted mid-word SHALL abort the word immediately; the line drops to 0 asynchronously, and the word is not resumed.

Structure
REQ-026 Sync-type encodings (SYNC_CMD = 2'b01, SYNC_DATA = 2'b10) and the state encoding SHALL live in shared package bm_pkg, also used by the decoder.
REQ-027 The half-bit and cycle counting SHALL be one sub-module, bm_half_timer, which produces half-bit strobes; shift, parity and FSM logic stay in manchester_tx.

Verification
REQ-028 Reset, then in_word = 16'h3582, in_type = 2'b01 -> data_out high for 12 cycles, low for 12, then bits 0011010110000010, parity 1, 160 cycles total; tx_busy falls 16 cycles later.
REQ-029 in_word = 16'h0001, in_type = 2'b10 -> sync low for 12 cycles then high for 12; parity bit 0; the downstream decoder reports word_type data, out = 16'h0001, error = 0.
REQ-030 in_word = 16'hFFFF, force_par_err = 1 -> parity bit 0 is transmitted; the decoder flags a parity error.
REQ-031 in_type = 2'b11 with in_valid -> one-cycle type_err pulse, in_ready stays high, data_out stays 0.
REQ-032 Drop clrn at cycle 80 of a word -> data_out = 0 in the same cycle; after release, a new word is accepted and transmitted correctly.
REQ-033 Hold in_valid high across two words -> the second is accepted exactly GAP_CYCLES + 1 cycles after the first parity ends, and in_ready stays low throughout.

Source files
------------

// File: rtl/bm_pkg.sv
// Shared Manchester definitions for the 1553-style encoder and decoder.
// Holds sync-type encodings, FSM state encoding and word framing constants.
package bm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_GAP    = 3'd4
    } bm_state_t;

    localparam logic [1:0] SYNC_CMD  = 2'b01;
    localparam logic [1:0] SYNC_DATA = 2'b10;

    // Word framing measured in Manchester half-bits.
    localparam int SYNC_HALVES   = 6;
    localparam int DATA_HALVES   = 32;
    localparam int PARITY_HALVES = 2;
    localparam int WORD_HALVES   = SYNC_HALVES + DATA_HALVES + PARITY_HALVES;

    function automatic logic type_valid(input logic [1:0] sync_type);
        return (sync_type == SYNC_CMD) || (sync_type == SYNC_DATA);
    endfunction

    // Parity bit that makes the count of ones over word plus parity odd.
    function automatic logic odd_parity(input logic [15:0] word);
        return ~(^word);
    endfunction

endpackage

// File: rtl/bm_half_timer.sv
// Half-bit timing for the Manchester encoder: strobes the last cycle of each
// half-bit, counts half-bits and total cycles since the word was accepted.
module bm_half_timer #(
    parameter int CLK_PER_HALF = 4,
    parameter int HW           = 6,
    parameter int CW           = 8
) (
    input  logic          clk_8M,
    input  logic          clrn,
    input  logic          start,
    input  logic          run,
    output logic          half_end,
    output logic [HW-1:0] half_idx,
    output logic [CW-1:0] cycle
);

    localparam int PW = (CLK_PER_HALF > 1) ? $clog2(CLK_PER_HALF) : 1;
    localparam logic [PW-1:0] HALF_LAST = PW'(CLK_PER_HALF - 1);

    logic [PW-1:0] cnt;

    assign half_end = run && (cnt == HALF_LAST);

    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn) begin
            cnt      <= '0;
            half_idx <= '0;
            cycle    <= '0;
        end else if (start) begin
            cnt      <= '0;
            half_idx <= '0;
            cycle    <= '0;
        end else if (run) begin
            cycle <= cycle + 1'b1;
            if (cnt == HALF_LAST) begin
                cnt      <= '0;
                half_idx <= half_idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/manchester_tx.sv
// Manchester word transmitter: sync, 16 data bits MSB first, odd parity, then
// an idle gap. Line level is registered and changes one cycle after acceptance.
module manchester_tx
    import bm_pkg::*;
#(
    parameter int CLK_PER_HALF = 4,
    parameter int GAP_CYCLES   = 16
) (
    input  logic        clk_8M,
    input  logic        clrn,
    input  logic [15:0] in_word,
    input  logic [1:0]  in_type,
    input  logic        in_valid,
    input  logic        force_par_err,
    output logic        in_ready,
    output logic        data_out,
    output logic        tx_busy,
    output logic        type_err
);

    localparam int HW = $clog2(WORD_HALVES + 1);
    localparam int CW = $clog2(WORD_HALVES * CLK_PER_HALF + GAP_CYCLES + 1);

    localparam logic [HW-1:0] IDX_SYNC_MID   = HW'(SYNC_HALVES / 2 - 1);
    localparam logic [HW-1:0] IDX_SYNC_LAST  = HW'(SYNC_HALVES - 1);
    localparam logic [HW-1:0] IDX_DATA_LAST  = HW'(SYNC_HALVES + DATA_HALVES - 1);
    localparam logic [HW-1:0] IDX_PAR_FIRST  = HW'(SYNC_HALVES + DATA_HALVES);
    localparam logic [CW-1:0] GAP_LAST_CYCLE = CW'(WORD_HALVES * CLK_PER_HALF + GAP_CYCLES - 1);

    bm_state_t     state;
    logic [15:0]   shreg;
    logic [1:0]    type_q;
    logic          par_q;
    logic          accept;
    logic          half_end;
    logic [HW-1:0] half_idx;
    logic [CW-1:0] cycle;

    assign accept = in_ready && in_valid && type_valid(in_type);

    bm_half_timer #(
        .CLK_PER_HALF(CLK_PER_HALF),
        .HW          (HW),
        .CW          (CW)
    ) u_timer (
        .clk_8M  (clk_8M),
        .clrn    (clrn),
        .start   (accept),
        .run     (tx_busy),
        .half_end(half_end),
        .half_idx(half_idx),
        .cycle   (cycle)
    );

    // Each transition loads the level for the half-bit that starts next cycle.
    always_ff @(posedge clk_8M or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            tx_busy  <= 1'b0;
            data_out <= 1'b0;
            type_err <= 1'b0;
            shreg    <= '0;
            type_q   <= '0;
            par_q    <= 1'b0;
        end else begin
            type_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg    <= in_word;
                        type_q   <= in_type;
                        par_q    <= odd_parity(in_word) ^ force_par_err;
                        state    <= ST_SYNC;
                        in_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        data_out <= (in_type == SYNC_CMD);
                    end else if (in_ready && in_valid) begin
                        type_err <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (half_end) begin
                        if (half_idx == IDX_SYNC_MID) begin
                            data_out <= (type_q != SYNC_CMD);
                        end else if (half_idx == IDX_SYNC_LAST) begin
                            state    <= ST_DATA;
                            data_out <= shreg[15];
                        end
                    end
                end
                ST_DATA: begin
                    if (half_end) begin
                        if (!half_idx[0]) begin
                            data_out <= ~shreg[15];
                        end else if (half_idx == IDX_DATA_LAST) begin
                            state    <= ST_PARITY;
                            data_out <= par_q;
                        end else begin
                            shreg    <= {shreg[14:0], 1'b0};
                            data_out <= shreg[14];
                        end
                    end
                end
                ST_PARITY: begin
                    if (half_end) begin
                        if (half_idx == IDX_PAR_FIRST) begin
                            data_out <= ~par_q;
                        end else begin
                            data_out <= 1'b0;
                            if (GAP_CYCLES == 0) begin
                                state    <= ST_IDLE;
                                in_ready <= 1'b1;
                                tx_busy  <= 1'b0;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    data_out <= 1'b0;
                    if (cycle == GAP_LAST_CYCLE) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    data_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
